// File: rtl/error_control_seq_pkg.sv
// -----------------------------------------------------------------------------
// error_control_seq_pkg
// Shared definitions for the sequential goal-error controller:
//   - FSM state encoding (also exported on the debug state bus)
//   - axis indices, which double as the correction priority (lower = higher)
//   - default word format and threshold/velocity magnitudes in whole units
//   - helper that maps an axis index to its ALIGN state
// Words are sign-magnitude: bit [N-1] is the sign, bits [N-2:0] the magnitude
// with FRAC_BITS fractional bits. +0 is all zeros.
// -----------------------------------------------------------------------------
package error_control_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALIGN_Y = 3'd1,
    ST_ALIGN_X = 3'd2,
    ST_ALIGN_Z = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_GOAL    = 3'd5
  } state_e;

  localparam int AXES = 3;

  // Axis index order is the correction priority: Y first, then X, then Z.
  localparam logic [1:0] AX_Y = 2'd0;
  localparam logic [1:0] AX_X = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  localparam int DEF_N_WIDTH    = 17;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_H_INT      = 10;  // enter threshold, cm or deg
  localparam int DEF_HYST_INT   = 2;   // exit margin below enter threshold
  localparam int DEF_VMAG_INT   = 30;  // command magnitude, cm/s
  localparam int DEF_RAMP_INT   = 3;   // ramp increment per sample
  localparam int DEF_SETTLE_CNT = 16;

  // ALIGN states are laid out consecutively after IDLE in axis order.
  function automatic state_e align_state(input logic [1:0] ax);
    return state_e'(3'(ax) + 3'd1);
  endfunction

endpackage

// File: rtl/error_control_seq_sm_mag_cmp.sv
// -----------------------------------------------------------------------------
// sm_mag_cmp
// Sign-magnitude threshold comparator for one error axis.
//   e_i     : error word, sign-magnitude
//   enter_o : |e| >  H          (start correcting this axis)
//   stay_o  : |e| >  H - HYST   (keep correcting once started)
//   neg_o   : error is strictly negative; -0 reports as non-negative
// Only the magnitude field is compared, so -0 behaves exactly like +0.
// -----------------------------------------------------------------------------
module sm_mag_cmp #(
  parameter int                 N_WIDTH = 17,
  parameter logic [N_WIDTH-1:0] H       = '0,
  parameter logic [N_WIDTH-1:0] HYST    = '0
) (
  input  logic [N_WIDTH-1:0] e_i,
  output logic               enter_o,
  output logic               stay_o,
  output logic               neg_o
);

  localparam int MW = N_WIDTH - 1;
  localparam logic [MW-1:0] H_MAG    = H[MW-1:0];
  localparam logic [MW-1:0] EXIT_MAG = H_MAG - HYST[MW-1:0];

  logic [MW-1:0] mag;

  assign mag     = e_i[MW-1:0];
  assign enter_o = mag > H_MAG;
  assign stay_o  = mag > EXIT_MAG;
  assign neg_o   = e_i[MW] & (|mag);

endmodule

// File: rtl/error_control_seq.sv
// -----------------------------------------------------------------------------
// error_control_seq
// Clocked goal-error controller between pose-error computation and the
// inverse-kinematics stage. Corrects one axis at a time (Y, then X, then Z)
// with enter/exit hysteresis, then requires SETTLE_CNT consecutive in-band
// samples while settling before declaring goal.
//
// Ports
//   ERROR_CTRL_SEQ_CLOCK_50          in   clock
//   ERROR_CTRL_SEQ_RESET_InLow       in   async reset, active low
//   ERROR_CTRL_SEQ_ENABLE_InHigh     in   run request; low returns to IDLE
//   ERROR_CTRL_SEQ_VALID_InHigh      in   X/Y/Z error sample valid
//   ERROR_CTRL_SEQ_{X,Y,Z}_InBus     in   sign-magnitude errors
//   ERROR_CTRL_SEQ_{VX,VY,WZ}_OutBus out  sign-magnitude velocity commands
//   ERROR_CTRL_SEQ_OUTVALID_OutHigh  out  one-cycle pulse after a command update
//   ERROR_CTRL_SEQ_GOAL_FLAG         out  goal reached, active low
//   ERROR_CTRL_SEQ_STATE_OutBus      out  FSM state (debug)
//
// Build option
//   ERROR_CTRL_RAMP_EN : active-axis command magnitude ramps by RAMP_STEP per
//   valid sample up to V_MAG, restarting at RAMP_STEP on axis entry or sign
//   flip. Undefined: commands are full V_MAG immediately.
// -----------------------------------------------------------------------------
module error_control_seq
  import error_control_seq_pkg::*;
#(
  parameter int                 N_WIDTH    = DEF_N_WIDTH,
  parameter int                 FRAC_BITS  = DEF_FRAC_BITS,
  parameter logic [N_WIDTH-1:0] H_Y        = N_WIDTH'(DEF_H_INT)    << FRAC_BITS,
  parameter logic [N_WIDTH-1:0] H_X        = N_WIDTH'(DEF_H_INT)    << FRAC_BITS,
  parameter logic [N_WIDTH-1:0] H_Z        = N_WIDTH'(DEF_H_INT)    << FRAC_BITS,
  parameter logic [N_WIDTH-1:0] HYST       = N_WIDTH'(DEF_HYST_INT) << FRAC_BITS,
  parameter logic [N_WIDTH-1:0] V_MAG      = N_WIDTH'(DEF_VMAG_INT) << FRAC_BITS,
  parameter int                 SETTLE_CNT = DEF_SETTLE_CNT,
  parameter logic [N_WIDTH-1:0] RAMP_STEP  = N_WIDTH'(DEF_RAMP_INT) << FRAC_BITS
) (
  input  logic               ERROR_CTRL_SEQ_CLOCK_50,
  input  logic               ERROR_CTRL_SEQ_RESET_InLow,
  input  logic               ERROR_CTRL_SEQ_ENABLE_InHigh,
  input  logic               ERROR_CTRL_SEQ_VALID_InHigh,
  input  logic [N_WIDTH-1:0] ERROR_CTRL_SEQ_X_InBus,
  input  logic [N_WIDTH-1:0] ERROR_CTRL_SEQ_Y_InBus,
  input  logic [N_WIDTH-1:0] ERROR_CTRL_SEQ_Z_InBus,
  output logic [N_WIDTH-1:0] ERROR_CTRL_SEQ_VX_OutBus,
  output logic [N_WIDTH-1:0] ERROR_CTRL_SEQ_VY_OutBus,
  output logic [N_WIDTH-1:0] ERROR_CTRL_SEQ_WZ_OutBus,
  output logic               ERROR_CTRL_SEQ_OUTVALID_OutHigh,
  output logic               ERROR_CTRL_SEQ_GOAL_FLAG,
  output logic [2:0]         ERROR_CTRL_SEQ_STATE_OutBus
);

  localparam int MW    = N_WIDTH - 1;
  localparam int CNT_W = $clog2(SETTLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CNT - 1);
  localparam logic [MW-1:0]    V_MAG_M  = V_MAG[MW-1:0];

  // Elaboration-time guard on the parameter set.
  if (SETTLE_CNT < 1 || HYST > H_Y || HYST > H_X || HYST > H_Z || RAMP_STEP == '0)
  begin : g_param_check
    $error("error_control_seq: illegal parameter set");
  end

  // ---------------------------------------------------------------------------
  // Per-axis comparators, indexed in priority order (Y, X, Z)
  // ---------------------------------------------------------------------------
  localparam logic [AXES-1:0][N_WIDTH-1:0] H_ARR = {H_Z, H_X, H_Y};

  logic [AXES-1:0][N_WIDTH-1:0] err;
  logic [AXES-1:0]              ent, stay, neg;

  assign err = {ERROR_CTRL_SEQ_Z_InBus, ERROR_CTRL_SEQ_X_InBus, ERROR_CTRL_SEQ_Y_InBus};

  for (genvar g = 0; g < AXES; g++) begin : g_cmp
    sm_mag_cmp #(
      .N_WIDTH (N_WIDTH),
      .H       (H_ARR[g]),
      .HYST    (HYST)
    ) u_cmp (
      .e_i     (err[g]),
      .enter_o (ent[g]),
      .stay_o  (stay[g]),
      .neg_o   (neg[g])
    );
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_WIDTH-1:0] vx_q, vy_q, wz_q, vx_d, vy_d, wz_d;
  logic               ov_q;
  logic               goal_n_q;
  logic [MW-1:0]      mag_d;
`ifdef ERROR_CTRL_RAMP_EN
  localparam logic [MW-1:0] STEP_MAG = RAMP_STEP[MW-1:0];
  localparam logic [MW-1:0] STEP_SAT = (STEP_MAG > V_MAG_M) ? V_MAG_M : STEP_MAG;
  logic [MW-1:0] mag_q;
  logic          cmd_neg_q;   // error sign behind the current command
  logic [MW:0]   sum;
`endif

  logic       act_vld, first_vld, nxt_align, nxt_neg;
  logic [1:0] act_ax, first_ax, nxt_ax;

  always_comb begin
    act_vld = 1'b0;
    act_ax  = AX_Y;
    case (state_q)
      ST_ALIGN_Y: begin act_vld = 1'b1; act_ax = AX_Y; end
      ST_ALIGN_X: begin act_vld = 1'b1; act_ax = AX_X; end
      ST_ALIGN_Z: begin act_vld = 1'b1; act_ax = AX_Z; end
      default:    ;
    endcase

    first_vld = |ent;
    first_ax  = ent[AX_Y] ? AX_Y : (ent[AX_X] ? AX_X : AX_Z);

    state_d = state_q;
    cnt_d   = '0;
    // A higher-priority entering axis preempts; otherwise the active axis is
    // kept while its stay test holds, and only then is the next entering axis
    // (or settling) considered.
    if (first_vld && (!act_vld || first_ax < act_ax || !stay[act_ax])) begin
      state_d = align_state(first_ax);
    end else if (act_vld && stay[act_ax]) begin
      state_d = state_q;
    end else if (state_q == ST_SETTLE) begin
      // SETTLE_CNT in-band samples seen while settling reach goal.
      if (cnt_q == CNT_LAST) state_d = ST_GOAL;
      else                   cnt_d   = cnt_q + 1'b1;
    end else if (state_q == ST_GOAL) begin
      state_d = ST_GOAL;
    end else begin
      state_d = ST_SETTLE;
    end

    nxt_align = 1'b1;
    nxt_ax    = AX_Y;
    case (state_d)
      ST_ALIGN_Y: nxt_ax = AX_Y;
      ST_ALIGN_X: nxt_ax = AX_X;
      ST_ALIGN_Z: nxt_ax = AX_Z;
      default:    nxt_align = 1'b0;
    endcase
    nxt_neg = neg[nxt_ax];

`ifdef ERROR_CTRL_RAMP_EN
    sum = {1'b0, mag_q} + {1'b0, STEP_MAG};
    if (!nxt_align)                                     mag_d = '0;
    else if (state_d != state_q || nxt_neg != cmd_neg_q) mag_d = STEP_SAT;
    else if (sum > {1'b0, V_MAG_M})                      mag_d = V_MAG_M;
    else                                                 mag_d = sum[MW-1:0];
`else
    mag_d = nxt_align ? V_MAG_M : '0;
`endif

    // VY opposes the X error; VX and WZ follow their error's sign.
    vx_d = '0;
    vy_d = '0;
    wz_d = '0;
    case (state_d)
      ST_ALIGN_Y: vx_d = {nxt_neg, mag_d};
      ST_ALIGN_X: vy_d = {~nxt_neg, mag_d};
      ST_ALIGN_Z: wz_d = {nxt_neg, mag_d};
      default:    ;
    endcase
  end

  always_ff @(posedge ERROR_CTRL_SEQ_CLOCK_50 or negedge ERROR_CTRL_SEQ_RESET_InLow) begin
    if (!ERROR_CTRL_SEQ_RESET_InLow) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      wz_q      <= '0;
      ov_q      <= 1'b0;
      goal_n_q  <= 1'b1;
`ifdef ERROR_CTRL_RAMP_EN
      mag_q     <= '0;
      cmd_neg_q <= 1'b0;
`endif
    end else if (!ERROR_CTRL_SEQ_ENABLE_InHigh) begin
      // Disable wins over VALID; the update pulse is given only on the edge
      // that actually leaves a running state.
      ov_q      <= (state_q != ST_IDLE);
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      wz_q      <= '0;
      goal_n_q  <= 1'b1;
`ifdef ERROR_CTRL_RAMP_EN
      mag_q     <= '0;
`endif
    end else if (ERROR_CTRL_SEQ_VALID_InHigh) begin
      ov_q      <= 1'b1;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      wz_q      <= wz_d;
      goal_n_q  <= (state_d != ST_GOAL);
`ifdef ERROR_CTRL_RAMP_EN
      mag_q     <= mag_d;
      cmd_neg_q <= nxt_neg;
`endif
    end else begin
      ov_q      <= 1'b0;
    end
  end

  assign ERROR_CTRL_SEQ_VX_OutBus        = vx_q;
  assign ERROR_CTRL_SEQ_VY_OutBus        = vy_q;
  assign ERROR_CTRL_SEQ_WZ_OutBus        = wz_q;
  assign ERROR_CTRL_SEQ_OUTVALID_OutHigh = ov_q;
  assign ERROR_CTRL_SEQ_GOAL_FLAG        = goal_n_q;
  assign ERROR_CTRL_SEQ_STATE_OutBus     = state_q;

endmodule

// File: tb/tb_error_control_seq.sv
// -----------------------------------------------------------------------------
// tb_error_control_seq
// Directed scenarios followed by randomized samples, each compared against a
// behavioural model of the controller's rules, plus fixed expected values at
// the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_error_control_seq;

  localparam int SC    = 16;
  localparam int HMAG  = 10 * 256;
  localparam int EXITM = 8 * 256;
  localparam int VM    = 30 * 256;
  localparam int STEP  = 3 * 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, vld = 1'b0;
  logic [16:0] xi = '0, yi = '0, zi = '0;
  logic [16:0] vx, vy, wz;
  logic        ov, goal_n;
  logic [2:0]  st;

  int n_chk = 0;
  int n_err = 0;

  // model state: 0 idle, 1..3 aligning Y/X/Z, 4 settling, 5 goal
  int m_state = 0, m_cnt = 0, m_mag = 0;
  bit m_neg = 1'b0, m_pulse = 1'b0;

  always #5 clk = ~clk;

  error_control_seq dut (
    .ERROR_CTRL_SEQ_CLOCK_50         (clk),
    .ERROR_CTRL_SEQ_RESET_InLow      (rst_n),
    .ERROR_CTRL_SEQ_ENABLE_InHigh    (en),
    .ERROR_CTRL_SEQ_VALID_InHigh     (vld),
    .ERROR_CTRL_SEQ_X_InBus          (xi),
    .ERROR_CTRL_SEQ_Y_InBus          (yi),
    .ERROR_CTRL_SEQ_Z_InBus          (zi),
    .ERROR_CTRL_SEQ_VX_OutBus        (vx),
    .ERROR_CTRL_SEQ_VY_OutBus        (vy),
    .ERROR_CTRL_SEQ_WZ_OutBus        (wz),
    .ERROR_CTRL_SEQ_OUTVALID_OutHigh (ov),
    .ERROR_CTRL_SEQ_GOAL_FLAG        (goal_n),
    .ERROR_CTRL_SEQ_STATE_OutBus     (st)
  );

  function automatic logic [16:0] cm(input int v);
    logic [15:0] m;
    m = 16'((v < 0 ? -v : v) * 256);
    return {(v < 0), m};
  endfunction

  function automatic int magof(input logic [16:0] v);
    return int'(v[15:0]);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // quiet samples never exceed an enter threshold
  function automatic logic [16:0] rnd_err(input bit quiet);
    int          k;
    logic [15:0] m;
    bit          s;
    k = quiet ? $urandom_range(0, 3) : $urandom_range(0, 9);
    s = 1'($urandom_range(0, 1));
    case (k)
      0:       m = '0;
      1:       m = 16'(HMAG);
      2:       m = 16'(EXITM);
      3:       m = 16'($urandom_range(0, 7 * 256));
      4:       m = 16'(HMAG + 1);
      5:       m = 16'(EXITM + 1);
      6:       m = 16'($urandom_range(8 * 256, 10 * 256));
      default: m = 16'($urandom_range(11 * 256, 60 * 256));
    endcase
    return {s, m};
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_mag = 0; m_neg = 1'b0; m_pulse = 1'b0;
  endtask

  // One clock edge of the controller's rules.
  task automatic model_clock(input bit e_en, input bit e_vld,
                             input logic [16:0] ey, input logic [16:0] ex, input logic [16:0] ez);
    logic [16:0] e [3];
    int want, cur, nstate;
    bit s;
    e[0] = ey; e[1] = ex; e[2] = ez;
    if (!e_en) begin
      m_pulse = (m_state != 0);
      m_state = 0; m_cnt = 0; m_mag = 0;
      return;
    end
    if (!e_vld) begin
      m_pulse = 1'b0;
      return;
    end
    m_pulse = 1'b1;
    want = -1;
    for (int a = 2; a >= 0; a--) if (magof(e[a]) > HMAG) want = a;
    cur = (m_state >= 1 && m_state <= 3) ? m_state - 1 : -1;
    if (cur >= 0 && magof(e[cur]) > EXITM && (want < 0 || want >= cur)) nstate = m_state;
    else if (want >= 0)  nstate = want + 1;
    else if (m_state == 4) nstate = (m_cnt == SC - 1) ? 5 : 4;
    else if (m_state == 5) nstate = 5;
    else                   nstate = 4;
    m_cnt = (m_state == 4 && nstate == 4) ? m_cnt + 1 : 0;
    if (nstate >= 1 && nstate <= 3) begin
      s = e[nstate-1][16] && (magof(e[nstate-1]) != 0);
`ifdef ERROR_CTRL_RAMP_EN
      if (nstate != m_state || s != m_neg) m_mag = imin(STEP, VM);
      else                                 m_mag = imin(m_mag + STEP, VM);
`else
      m_mag = VM;
`endif
      m_neg = s;
    end else begin
      m_mag = 0;
    end
    m_state = nstate;
  endtask

  task automatic check_all(input string tag);
    logic [16:0] evx, evy, ewz;
    evx = (m_state == 1) ? {m_neg, 16'(m_mag)} : '0;
    evy = (m_state == 2) ? {~m_neg, 16'(m_mag)} : '0;
    ewz = (m_state == 3) ? {m_neg, 16'(m_mag)} : '0;
    chk({tag, ".vx"},    vx,           evx);
    chk({tag, ".vy"},    vy,           evy);
    chk({tag, ".wz"},    wz,           ewz);
    chk({tag, ".ov"},    17'(ov),      17'(m_pulse));
    chk({tag, ".goal"},  17'(goal_n),  17'(m_state != 5));
    chk({tag, ".state"}, 17'(st),      17'(m_state));
  endtask

  task automatic step(input string tag, input bit s_en, input bit s_vld,
                      input logic [16:0] sx, input logic [16:0] sy, input logic [16:0] sz);
    en = s_en; vld = s_vld; xi = sx; yi = sy; zi = sz;
    @(posedge clk);
    model_clock(s_en, s_vld, sy, sx, sz);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [16:0] negz;
    bit quiet;
    negz = 17'h10000;

    // 1: reset held with random inputs
    model_reset();
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom_range(0, 1)); vld = 1'($urandom_range(0, 1));
      xi = rnd_err(1'b0); yi = rnd_err(1'b0); zi = rnd_err(1'b0);
      @(posedge clk); #1;
      check_all("reset");
    end
    rst_n = 1'b1;

    // 2: Y corrected first, hysteresis, then X
    step("t2a", 1, 1, cm(-15), cm(20), cm(0));
`ifndef ERROR_CTRL_RAMP_EN
    chk("t2a_vx", vx, cm(30));
`endif
    step("t2b", 1, 1, cm(-15), cm(9), cm(0));
`ifndef ERROR_CTRL_RAMP_EN
    chk("t2b_vx_hyst", vx, cm(30));
`endif
    step("t2c", 1, 1, cm(-15), cm(7), cm(0));
    chk("t2c_vx", vx, cm(0));
`ifndef ERROR_CTRL_RAMP_EN
    chk("t2c_vy", vy, cm(30));
`endif

    // no valid: hold
    step("hold", 1, 0, cm(50), cm(50), cm(50));
    chk("hold_state", 17'(st), 17'd2);

    // 3: settle to goal, then Z re-entry clears goal on the same edge
    step("t3_leave", 1, 1, cm(0), cm(0), cm(0));
    for (int i = 0; i < SC - 1; i++) step("t3_settle", 1, 1, cm(0), cm(0), cm(0));
    chk("t3_goal_pre", 17'(goal_n), 17'd1);
    step("t3_last", 1, 1, cm(0), cm(0), cm(0));
    chk("t3_goal", 17'(goal_n), 17'd0);
    step("t3_z", 1, 1, cm(0), cm(0), cm(12));
    chk("t3_goal_clr", 17'(goal_n), 17'd1);
`ifndef ERROR_CTRL_RAMP_EN
    chk("t3_wz", wz, cm(30));
`endif

    // 4: Z sign flip, then Y preempts Z
    step("t4_flip", 1, 1, cm(0), cm(0), cm(-20));
`ifndef ERROR_CTRL_RAMP_EN
    chk("t4_wz", wz, cm(-30));
`endif
    step("t4_pre", 1, 1, cm(0), cm(-11), cm(-20));
    chk("t4_wz0", wz, cm(0));
`ifndef ERROR_CTRL_RAMP_EN
    chk("t4_vx", vx, cm(-30));
`endif

    // 5: negative zero is in band; exactly-threshold does not enter
    step("t5", 1, 1, cm(0), negz, cm(0));
    chk("t5_state", 17'(st), 17'd4);
    chk("t5_vx", vx, cm(0));
    step("t5_h", 1, 1, cm(10), cm(-10), cm(10));
    chk("t5_h_state", 17'(st), 17'd4);

    // 6: ramp, saturate, sign flip, disable mid-ramp
    step("t6_dis", 0, 1, cm(0), cm(0), cm(0));
    chk("t6_dis_ov", 17'(ov), 17'd1);
    step("t6_dis2", 0, 1, cm(0), cm(0), cm(0));
    for (int i = 0; i < 12; i++) begin
      step("t6_ramp", 1, 1, cm(0), cm(50), cm(0));
`ifdef ERROR_CTRL_RAMP_EN
      chk("t6_ramp_vx", vx, cm(3 * imin(i + 1, 10)));
`endif
    end
    step("t6_flip", 1, 1, cm(0), cm(-50), cm(0));
`ifdef ERROR_CTRL_RAMP_EN
    chk("t6_flip_vx", vx, cm(-3));
`endif
    step("t6_flip2", 1, 1, cm(0), cm(-50), cm(0));
    step("t6_drop", 0, 0, cm(0), cm(-50), cm(0));
    chk("t6_drop_vx", vx, cm(0));

    // randomized samples with occasional asynchronous reset
    quiet = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) quiet = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      step("rnd", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           rnd_err(quiet), rnd_err(quiet), rnd_err(quiet));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
